alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single registered ALU (operands in, result valid one CLK later) between two requesters: REQ0 (execute stage) and REQ1 (address/branch-target unit).
- Round-robin grant, valid/ready handshake on both sides, tag tracking of the in-flight op.
- 1-entry result hold register absorbs response backpressure; sits between the requesters and the ALU instance.

Parameters:
- W, 32, operand/result width (must match ALU)
- OPW, 5, opcode width (ALU_* codes from defs.v)

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- REQ0_VALID  in  1  requester 0 has an op
- REQ0_RS1  in  W  operand 1
- REQ0_RS2  in  W  operand 2
- REQ0_OP  in  OPW  ALU_* opcode
- REQ0_READY  out  1  op accepted this cycle (VALID&&READY = transfer)
- REQ1_VALID, REQ1_RS1, REQ1_RS2, REQ1_OP, REQ1_READY  same as REQ0, requester 1
- RESP0_VALID  out  1  RESP_DATA belongs to requester 0
- RESP0_READY  in  1  requester 0 takes response
- RESP1_VALID  out  1  RESP_DATA belongs to requester 1
- RESP1_READY  in  1  requester 1 takes response
- RESP_DATA  out  W  result
- ALU_RS1  out  W  to ALU RS1
- ALU_RS2  out  W  to ALU RS2
- ALU_OP  out  OPW  to ALU OP
- ALU_RD  in  W  from ALU RD (registered in ALU, 1-cycle latency)

Behaviour:
- State: last_grant (1b), infl_v/infl_id (op issued last cycle, result on ALU_RD now), hold_v/hold_id/hold_data.
- Reset (RST=1 at posedge): infl_v=0, hold_v=0, last_grant=1 (REQ0 wins first tie). All RESPx_VALID=0, REQx_READY=0, ALU_RS1/RS2/OP=0 during and after reset until a grant. Reset mid-operation drops in-flight and held results; no response is ever emitted for them.
- Response select (combinational):
  - If hold_v: RESP_DATA=hold_data, RESP[hold_id]_VALID=1.
  - Else if infl_v: RESP_DATA=ALU_RD, RESP[infl_id]_VALID=1.
  - Else both VALID=0, RESP_DATA=0.
  - At most one RESPx_VALID high per cycle.
- Response accepted = active VALID && matching RESPx_READY.
- stall = hold_v || (infl_v && !RESP[infl_id]_READY).
- Grant (combinational, only when !stall and !RST):
  - Only one VALID: grant it.
  - Both VALID: grant !last_grant.
  - REQx_READY=1 for the granted requester only.
  - ALU_RS1/RS2/OP mux the granted requester's fields.
  - No grant: ALU_* = 0. The ALU's computed value is ignored because infl_v=0.
- Sequential update at posedge:
  - infl_v <= grant_any; infl_id <= granted id; last_grant <= granted id if grant_any.
  - If infl_v && !hold_v && response not accepted: hold_v<=1, hold_id<=infl_id, hold_data<=ALU_RD.
  - If hold_v && accepted: hold_v<=0.
- Latency: a request accepted in cycle N yields RESPx_VALID in cycle N+1 (no stall). Throughput is 1 op/cycle sustained.
- Backpressure: a stalled in-flight result moves to hold; no grants while hold_v. After hold drains, grants resume the following cycle (1-cycle bubble). At most one pending result is ever outstanding, so the ALU register is never overwritten while unread.
- REQx_READY depends combinationally on VALID and RESP_READY. Requesters must not make VALID depend on READY.
- A requester must hold VALID and fields stable until READY.
- Simultaneous: an issue to requester A while B's response is accepted in the same cycle is legal. RESP_READY asserted without VALID is ignored.

Test Plan:
- Reset then single op: REQ0 ALU_ADD RS1=5 RS2=7 in cycle 1 -> REQ0_READY=1 in cycle 1; RESP0_VALID=1, RESP_DATA=12 in cycle 2; RESP1_VALID=0 throughout.
- Contention: both VALID continuously, REQ0 ALU_SUB 10-3, REQ1 ALU_XOR 0xF0^0xFF, RESP READYs=1 -> grants alternate 0,1,0,1 starting with REQ0; responses 7, 0x0F, 7, 0x0F one cycle after each grant; no idle cycles.
- Backpressure: REQ1 ALU_SLL 1<<4 accepted, RESP1_READY=0 for 3 cycles -> RESP1_VALID, RESP_DATA=16 stable all 3 cycles; REQ0_READY=0 while held; after RESP1_READY=1, REQ0 granted the next cycle.
- Signed compare: REQ0 ALU_SLT 0xFFFFFFFF vs 1 -> 1; ALU_SLTU same operands -> 0.
- Reset mid-operation: REQ0 accepted in cycle N, RST=1 in cycle N+1 -> no RESP0_VALID in N+1 or afterwards; READYs=0 during reset; first post-reset tie is granted to REQ0.
- Idle: no VALID for 10 cycles -> ALU_OP/RS1/RS2=0 and both RESPx_VALID=0 every cycle.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
//   Bundles the two requester channels, the shared response channel and the
//   ALU-facing signals of alu_arbiter.
//
//   Requester side (per requester x = 0/1):
//     reqx_valid / reqx_rs1 / reqx_rs2 / reqx_op   requester -> arbiter
//     reqx_ready                                   arbiter -> requester
//   Response side:
//     resp0_valid / resp1_valid / resp_data        arbiter -> requesters
//     resp0_ready / resp1_ready                    requesters -> arbiter
//   ALU side:
//     alu_rs1 / alu_rs2 / alu_op                   arbiter -> ALU
//     alu_rd                                       ALU -> arbiter (registered)
//
//   modport slave  : the arbiter
//   modport master : the environment (requesters plus the ALU)
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
    parameter int W   = 32,
    parameter int OPW = 5
);
    logic           req0_valid;
    logic [W-1:0]   req0_rs1;
    logic [W-1:0]   req0_rs2;
    logic [OPW-1:0] req0_op;
    logic           req0_ready;

    logic           req1_valid;
    logic [W-1:0]   req1_rs1;
    logic [W-1:0]   req1_rs2;
    logic [OPW-1:0] req1_op;
    logic           req1_ready;

    logic           resp0_valid;
    logic           resp0_ready;
    logic           resp1_valid;
    logic           resp1_ready;
    logic [W-1:0]   resp_data;

    logic [W-1:0]   alu_rs1;
    logic [W-1:0]   alu_rs2;
    logic [OPW-1:0] alu_op;
    logic [W-1:0]   alu_rd;

    modport slave (
        input  req0_valid, req0_rs1, req0_rs2, req0_op,
        output req0_ready,
        input  req1_valid, req1_rs1, req1_rs2, req1_op,
        output req1_ready,
        output resp0_valid, resp1_valid, resp_data,
        input  resp0_ready, resp1_ready,
        output alu_rs1, alu_rs2, alu_op,
        input  alu_rd
    );

    modport master (
        output req0_valid, req0_rs1, req0_rs2, req0_op,
        input  req0_ready,
        output req1_valid, req1_rs1, req1_rs2, req1_op,
        input  req1_ready,
        input  resp0_valid, resp1_valid, resp_data,
        output resp0_ready, resp1_ready,
        input  alu_rs1, alu_rs2, alu_op,
        output alu_rd
    );
endinterface

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one registered ALU (result on alu_rd one CLK after the operands)
//   between requester 0 (execute stage) and requester 1 (address/branch-target
//   unit). Round-robin grant on ties, valid/ready on both the request and the
//   response side, and a single-entry hold register that parks a result whose
//   owner is not ready so the ALU register is never overwritten while unread.
//
//   Ports:
//     CLK  clock
//     RST  synchronous active-high reset
//     bus  alu_arbiter_if.slave: both request channels, the shared response
//          channel (resp0_valid/resp1_valid/resp_data with per-owner ready)
//          and the ALU operand/opcode outputs plus the ALU result input.
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int W   = 32,
    parameter int OPW = 5
) (
    input  logic         CLK,
    input  logic         RST,
    alu_arbiter_if.slave bus
);
    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;

    // Arbitration history: the requester that won the most recent grant.
    req_id_e      last_grant;

    // Op issued last cycle; its result is on alu_rd this cycle.
    logic         infl_v;
    req_id_e      infl_id;

    // Parked result waiting for its owner to accept it.
    logic         hold_v;
    req_id_e      hold_id;
    logic [W-1:0] hold_data;

    logic         resp_v;
    req_id_e      resp_id;
    logic         resp_acc;
    logic         infl_ready;
    logic         stall;
    logic         hold_load;
    logic         grant_any;
    req_id_e      grant_id;

    // -------------------------------------------------------------------------
    // Response select: a parked result always goes out before anything else.
    // The result of an op caught by reset is never presented.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block is given a default before any
        // branch, so no path leaves it unassigned and no latch is inferred.
        resp_v        = 1'b0;
        resp_id       = REQ0;
        bus.resp_data = '0;
        if (!RST) begin
            if (hold_v) begin
                resp_v        = 1'b1;
                resp_id       = hold_id;
                bus.resp_data = hold_data;
            end else if (infl_v) begin
                resp_v        = 1'b1;
                resp_id       = infl_id;
                bus.resp_data = bus.alu_rd;
            end
        end
    end

    assign bus.resp0_valid = resp_v && (resp_id == REQ0);
    assign bus.resp1_valid = resp_v && (resp_id == REQ1);

    // A ready from a requester that has no valid response is ignored.
    assign resp_acc = (bus.resp0_valid && bus.resp0_ready) ||
                      (bus.resp1_valid && bus.resp1_ready);

    // Ready of whichever requester owns the in-flight result.
    assign infl_ready = (infl_id == REQ1) ? bus.resp1_ready : bus.resp0_ready;

    // A new op may issue only if the ALU register will be free to take it:
    // nothing is parked, and any in-flight result leaves this cycle. When a
    // parked result drains there is deliberately no issue in the same cycle.
    assign stall = hold_v || (infl_v && !infl_ready);

    // In-flight result not taken this cycle: park it.
    assign hold_load = infl_v && !hold_v && !resp_acc;

    // -------------------------------------------------------------------------
    // Grant: a lone requester wins outright; on a tie the requester that did
    // not win last time goes first.
    // -------------------------------------------------------------------------
    always_comb begin
        grant_any = 1'b0;
        grant_id  = REQ0;
        if (!RST && !stall) begin
            case ({bus.req1_valid, bus.req0_valid})
                2'b01: begin
                    grant_any = 1'b1;
                    grant_id  = REQ0;
                end
                2'b10: begin
                    grant_any = 1'b1;
                    grant_id  = REQ1;
                end
                2'b11: begin
                    grant_any = 1'b1;
                    grant_id  = (last_grant == REQ0) ? REQ1 : REQ0;
                end
                default: begin
                    grant_any = 1'b0;
                    grant_id  = REQ0;
                end
            endcase
        end
    end

    assign bus.req0_ready = grant_any && (grant_id == REQ0);
    assign bus.req1_ready = grant_any && (grant_id == REQ1);

    // ALU inputs follow the winner; zero when idle so the ALU sees quiet
    // inputs (its output is ignored anyway because infl_v stays low).
    always_comb begin
        bus.alu_rs1 = '0;
        bus.alu_rs2 = '0;
        bus.alu_op  = '0;
        if (grant_any) begin
            if (grant_id == REQ1) begin
                bus.alu_rs1 = bus.req1_rs1;
                bus.alu_rs2 = bus.req1_rs2;
                bus.alu_op  = bus.req1_op;
            end else begin
                bus.alu_rs1 = bus.req0_rs1;
                bus.alu_rs2 = bus.req0_rs2;
                bus.alu_op  = bus.req0_op;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values, regardless of statement order.
        if (RST) begin
            last_grant <= REQ1;
            infl_v     <= 1'b0;
            infl_id    <= REQ0;
            hold_v     <= 1'b0;
            hold_id    <= REQ0;
        end else begin
            infl_v <= grant_any;
            if (grant_any) begin
                infl_id    <= grant_id;
                last_grant <= grant_id;
            end
            if (hold_load) begin
                hold_v  <= 1'b1;
                hold_id <= infl_id;
            end else if (hold_v && resp_acc) begin
                hold_v <= 1'b0;
            end
        end
    end

    // NOTE: the hold data register has no reset; it is only ever observed
    // while hold_v is set, and hold_v is cleared by reset.
    always_ff @(posedge CLK) begin
        if (!RST && hold_load) begin
            hold_data <= bus.alu_rd;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed scenarios followed by randomized traffic. A behavioural model
//   keeps a queue of results owed to the requesters and decides from the
//   arbitration rules which requester may issue each cycle; every DUT output
//   is compared with it on the falling edge. The ALU itself is emulated by a
//   registered block driving alu_rd.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
    localparam int W   = 32;
    localparam int OPW = 5;

    localparam logic [OPW-1:0] ALU_ADD  = 5'd0;
    localparam logic [OPW-1:0] ALU_SUB  = 5'd1;
    localparam logic [OPW-1:0] ALU_SLL  = 5'd2;
    localparam logic [OPW-1:0] ALU_SLT  = 5'd3;
    localparam logic [OPW-1:0] ALU_SLTU = 5'd4;
    localparam logic [OPW-1:0] ALU_XOR  = 5'd5;
    localparam logic [OPW-1:0] ALU_SRL  = 5'd6;
    localparam logic [OPW-1:0] ALU_SRA  = 5'd7;
    localparam logic [OPW-1:0] ALU_OR   = 5'd8;
    localparam logic [OPW-1:0] ALU_AND  = 5'd9;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    alu_arbiter_if #(.W(W), .OPW(OPW)) bus ();

    alu_arbiter #(.W(W), .OPW(OPW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    function automatic logic [W-1:0] alu_ref(input logic [OPW-1:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return W'($signed(a) >>> b[4:0]);
            ALU_SLT:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            ALU_SLTU: return (a < b) ? W'(1) : W'(0);
            ALU_XOR:  return a ^ b;
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return '0;
        endcase
    endfunction

    // Registered ALU stand-in: result appears one CLK after its operands.
    always @(posedge CLK) begin
        bus.alu_rd <= alu_ref(bus.alu_op, bus.alu_rs1, bus.alu_rs2);
    end

    // ---------------------------------------------------------------- model
    typedef struct {
        logic         id;
        logic [W-1:0] data;
        int           issue;
    } pend_t;

    pend_t q[$];
    logic  mdl_last;
    int    cyc;

    int checks;
    int errors;

    // Values sampled in the most recent cycle, for directed checks.
    logic           obs_r0rdy, obs_r1rdy, obs_p0v, obs_p1v;
    logic [W-1:0]   obs_data, obs_rs1, obs_rs2;
    logic [OPW-1:0] obs_op;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (cycle %0d): observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: compare all outputs with the model at the falling edge,
    // then advance the model at the rising edge.
    task automatic cycle();
        int             winner;
        logic           rst_now, exp_rv, exp_rid, exp_acc, may_grant;
        logic [W-1:0]   exp_rdata, exp_rs1, exp_rs2;
        logic [OPW-1:0] exp_op;

        @(negedge CLK);
        rst_now   = RST;
        obs_r0rdy = bus.req0_ready;
        obs_r1rdy = bus.req1_ready;
        obs_p0v   = bus.resp0_valid;
        obs_p1v   = bus.resp1_valid;
        obs_data  = bus.resp_data;
        obs_rs1   = bus.alu_rs1;
        obs_rs2   = bus.alu_rs2;
        obs_op    = bus.alu_op;

        exp_rv    = 1'b0;
        exp_rid   = 1'b0;
        exp_rdata = '0;
        if (!rst_now && q.size() > 0) begin
            exp_rv    = 1'b1;
            exp_rid   = q[0].id;
            exp_rdata = q[0].data;
        end
        exp_acc = exp_rv && (exp_rid ? bus.resp1_ready : bus.resp0_ready);

        // Issue allowed when nothing is owed, or the only owed result was
        // issued last cycle and leaves now.
        may_grant = !rst_now && (q.size() == 0 || (q[0].issue == cyc - 1 && exp_acc));

        winner = -1;
        if (may_grant) begin
            if (bus.req0_valid && bus.req1_valid) winner = mdl_last ? 0 : 1;
            else if (bus.req0_valid)              winner = 0;
            else if (bus.req1_valid)              winner = 1;
        end

        exp_rs1 = '0;
        exp_rs2 = '0;
        exp_op  = '0;
        if (winner == 0) begin
            exp_rs1 = bus.req0_rs1; exp_rs2 = bus.req0_rs2; exp_op = bus.req0_op;
        end else if (winner == 1) begin
            exp_rs1 = bus.req1_rs1; exp_rs2 = bus.req1_rs2; exp_op = bus.req1_op;
        end

        check("req0_ready",  W'(obs_r0rdy), W'(winner == 0));
        check("req1_ready",  W'(obs_r1rdy), W'(winner == 1));
        check("resp0_valid", W'(obs_p0v),   W'(exp_rv && !exp_rid));
        check("resp1_valid", W'(obs_p1v),   W'(exp_rv && exp_rid));
        if (!rst_now) check("resp_data", obs_data, exp_rdata);
        check("alu_op",  W'(obs_op), W'(exp_op));
        check("alu_rs1", obs_rs1, exp_rs1);
        check("alu_rs2", obs_rs2, exp_rs2);

        @(posedge CLK);
        if (rst_now) begin
            q.delete();
            mdl_last = 1'b1;
        end else begin
            if (exp_acc) void'(q.pop_front());
            if (winner >= 0) begin
                q.push_back('{id: (winner == 1), data: alu_ref(exp_op, exp_rs1, exp_rs2), issue: cyc});
                mdl_last = (winner == 1);
            end
        end
        cyc++;
        #1;
    endtask

    task automatic drive0(input logic v, input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req0_valid = v; bus.req0_op = op; bus.req0_rs1 = a; bus.req0_rs2 = b;
    endtask

    task automatic drive1(input logic v, input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req1_valid = v; bus.req1_op = op; bus.req1_rs1 = a; bus.req1_rs2 = b;
    endtask

    function automatic logic [W-1:0] rand_operand();
        return ($urandom_range(0, 1) == 0) ? W'($urandom) : W'($urandom_range(0, 40));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [OPW-1:0] op_tbl [10];
        logic [W-1:0]   exp_data [4];
        logic           exp_r0 [4];

        op_tbl = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
                   ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND};
        checks = 0; errors = 0; cyc = 0;
        q.delete(); mdl_last = 1'b1;

        RST = 1'b1;
        drive0(1'b0, '0, '0, '0);
        drive1(1'b0, '0, '0, '0);
        bus.resp0_ready = 1'b1;
        bus.resp1_ready = 1'b1;
        #1;

        // Reset: nothing offered, nothing accepted.
        cycle();
        check("rst_req0_ready", W'(obs_r0rdy), '0);
        cycle();

        // Single op: accepted this cycle, result next cycle.
        RST = 1'b0;
        drive0(1'b1, ALU_ADD, 32'd5, 32'd7);
        cycle();
        check("single_ready", W'(obs_r0rdy), W'(1));
        check("single_alu_op", W'(obs_op), W'(ALU_ADD));
        drive0(1'b0, '0, '0, '0);
        cycle();
        check("single_resp_valid", W'(obs_p0v), W'(1));
        check("single_resp_data", obs_data, 32'd12);
        check("single_resp1_valid", W'(obs_p1v), '0);

        // Backpressure on requester 1 while requester 0 waits.
        drive1(1'b1, ALU_SLL, 32'd1, 32'd4);
        bus.resp1_ready = 1'b0;
        cycle();
        check("bp_issue", W'(obs_r1rdy), W'(1));
        drive1(1'b0, '0, '0, '0);
        drive0(1'b1, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_held_valid", W'(obs_p1v), W'(1));
            check("bp_held_data", obs_data, 32'd16);
            check("bp_req0_blocked", W'(obs_r0rdy), '0);
        end
        bus.resp1_ready = 1'b1;
        cycle();
        check("bp_drain_valid", W'(obs_p1v), W'(1));
        check("bp_drain_bubble", W'(obs_r0rdy), '0);
        cycle();
        check("bp_resume_grant", W'(obs_r0rdy), W'(1));

        // Signed vs unsigned compare on the same operands.
        drive0(1'b1, ALU_SLTU, 32'hFFFF_FFFF, 32'd1);
        cycle();
        check("slt_result", obs_data, 32'd1);
        check("sltu_grant", W'(obs_r0rdy), W'(1));
        drive0(1'b0, '0, '0, '0);
        drive1(1'b1, ALU_XOR, 32'hF0, 32'hFF);
        cycle();
        check("sltu_result", obs_data, 32'd0);
        check("xor_grant", W'(obs_r1rdy), W'(1));

        // Contention: requester 1 won last, so requester 0 leads.
        drive0(1'b1, ALU_SUB, 32'd10, 32'd3);
        exp_r0   = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_data = '{32'h0F, 32'd7, 32'h0F, 32'd7};
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("rr_req0_ready", W'(obs_r0rdy), W'(exp_r0[i]));
            check("rr_req1_ready", W'(obs_r1rdy), W'(!exp_r0[i]));
            check("rr_resp_data", obs_data, exp_data[i]);
        end
        drive0(1'b0, '0, '0, '0);
        drive1(1'b0, '0, '0, '0);
        cycle();
        check("rr_last_resp", obs_data, 32'h0F);

        // Reset with an op in flight: its result is dropped.
        drive0(1'b1, ALU_ADD, 32'd5, 32'd7);
        cycle();
        check("mid_rst_issue", W'(obs_r0rdy), W'(1));
        RST = 1'b1;
        drive1(1'b1, ALU_XOR, 32'hF0, 32'hFF);
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("mid_rst_no_resp", W'(obs_p0v), '0);
            check("mid_rst_ready0", W'(obs_r0rdy), '0);
            check("mid_rst_ready1", W'(obs_r1rdy), '0);
        end
        RST = 1'b0;
        cycle();
        check("post_rst_tie0", W'(obs_r0rdy), W'(1));
        check("post_rst_tie1", W'(obs_r1rdy), '0);
        check("post_rst_no_stale", W'(obs_p0v), '0);
        drive0(1'b0, '0, '0, '0);
        drive1(1'b0, '0, '0, '0);
        cycle();
        check("post_rst_resp", obs_data, 32'd12);

        // Idle.
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("idle_alu_op", W'(obs_op), '0);
            check("idle_alu_rs1", obs_rs1, '0);
            check("idle_resp_valid", W'(obs_p0v | obs_p1v), '0);
        end

        // Randomized traffic; requesters hold fields until accepted.
        for (int n = 0; n < 1500; n++) begin
            RST = ($urandom_range(0, 99) == 0);
            if (!bus.req0_valid || obs_r0rdy)
                drive0($urandom_range(0, 2) != 0, op_tbl[$urandom_range(0, 9)], rand_operand(), rand_operand());
            if (!bus.req1_valid || obs_r1rdy)
                drive1($urandom_range(0, 2) != 0, op_tbl[$urandom_range(0, 9)], rand_operand(), rand_operand());
            bus.resp0_ready = ($urandom_range(0, 3) != 0);
            bus.resp1_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
